// File: rtl/encoder_stream_pkg.sv
// Shared types and helpers for the encoder_stream set-bit iterator.
package encoder_stream_pkg;

  // Widest vector the bit-clear helper supports; instances narrow it by casting.
  localparam int MAX_W = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Return v with bit idx forced to zero; used to retire an emitted index.
  function automatic logic [MAX_W-1:0] clear_bit(input logic [MAX_W-1:0] v,
                                                 input logic [31:0] idx);
    return v & ~(MAX_W'(1) << idx);
  endfunction

endpackage

// File: rtl/encoder_stream_encoder.sv
// Priority encoder: index of the lowest set bit of x, zero flags an empty vector.
module encoder_stream_encoder #(
  parameter int W = 32,
  parameter int E = $clog2(W)
) (
  input  logic [W-1:0] x,
  output logic [E-1:0] n,
  output logic         zero
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    n = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) n = E'(i);
    end
  end

  assign zero = (x == '0);

endmodule

// File: rtl/encoder_stream.sv
// Streams the index of every set bit of an accepted vector, one beat per cycle.
module encoder_stream
  import encoder_stream_pkg::*;
#(
  parameter int W             = 32,
  parameter bit OPT_MSB_FIRST = 1'b0,
  parameter int E             = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_x,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [E-1:0] out_n,
  output logic [E-1:0] out_cnt,
  output logic         out_last,
  output logic         out_empty,
  input  logic         out_rdy
);

  state_t         state, state_d;
  logic [W-1:0]   r;
  logic [W-1:0]   src;
  logic [W-1:0]   enc_in;
  logic [W-1:0]   r_next;
  logic [E-1:0]   enc_n;
  logic [E-1:0]   p;
  logic           enc_zero;
  logic           accept;
  logic           advance;
  logic           finish;

  // Final beat handshaking frees the block for a new vector in the same cycle.
  assign finish  = out_vld & out_rdy & out_last;
  assign advance = out_vld & out_rdy & ~out_last;
  assign in_rdy  = (state == IDLE) | finish;
  assign accept  = in_vld & in_rdy;

  // A new vector is scanned directly on accept; otherwise continue on the residue.
  assign src = accept ? in_x : r;

  // MSB-first reuses the lowest-bit encoder on a bit-reversed copy.
  always_comb begin
    enc_in = src;
    if (OPT_MSB_FIRST) begin
      for (int i = 0; i < W; i++) enc_in[i] = src[W-1-i];
    end
  end

  encoder_stream_encoder #(
    .W (W),
    .E (E)
  ) u_encoder (
    .x    (enc_in),
    .n    (enc_n),
    .zero (enc_zero)
  );

  // Map the encoder result back to a real index; an empty vector reports 0.
  always_comb begin
    if (enc_zero)           p = '0;
    else if (OPT_MSB_FIRST) p = E'(W - 1) - enc_n;
    else                    p = enc_n;
    r_next = W'(clear_bit(MAX_W'(src), 32'(p)));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: any accept lands in EMIT, the last beat without a refill returns to IDLE.
  always_comb begin
    state_d = state;
    if (accept)      state_d = EMIT;
    else if (finish) state_d = IDLE;
  end

  // Beat registers and residue: load on accept, step on each non-final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= '0;
      out_vld   <= 1'b0;
      out_n     <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
      out_empty <= 1'b0;
    end else if (accept) begin
      r         <= r_next;
      out_vld   <= 1'b1;
      out_n     <= p;
      out_cnt   <= '0;
      out_last  <= (r_next == '0);
      out_empty <= (in_x == '0);
    end else if (advance) begin
      r         <= r_next;
      out_n     <= p;
      out_cnt   <= out_cnt + 1'b1;
      out_last  <= (r_next == '0);
      out_empty <= 1'b0;
    end else if (finish) begin
      out_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_stream.sv
// Directed bench for encoder_stream: LSB-first and MSB-first instances in lockstep.
module tb_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_x;
  logic       out_rdy;

  logic       l_in_rdy, l_vld, l_last, l_empty;
  logic [2:0] l_n, l_cnt;
  logic       m_in_rdy, m_vld, m_last, m_empty;
  logic [2:0] m_n, m_cnt;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  encoder_stream #(.W(8), .OPT_MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_rdy(l_in_rdy),
    .out_vld(l_vld), .out_n(l_n), .out_cnt(l_cnt), .out_last(l_last),
    .out_empty(l_empty), .out_rdy(out_rdy));

  encoder_stream #(.W(8), .OPT_MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_rdy(m_in_rdy),
    .out_vld(m_vld), .out_n(m_n), .out_cnt(m_cnt), .out_last(m_last),
    .out_empty(m_empty), .out_rdy(out_rdy));

  // Beat order is packed as nibbles: nibble b holds the index expected on beat b.
  typedef struct packed {
    logic [7:0]  x;
    logic [3:0]  nb;
    logic [31:0] lsb;
    logic [31:0] msb;
    logic        empty;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector, then walk every beat with out_rdy held high.
  task automatic send(input vec_t v);
    logic [31:0] ls, ms;
    ls = v.lsb;
    ms = v.msb;
    in_vld = 1'b1;
    in_x   = v.x;
    chk("in_rdy_before_accept", 32'(l_in_rdy), 32'd1);
    tick();
    in_vld = 1'b0;
    in_x   = ~v.x;
    for (int b = 0; b < int'(v.nb); b++) begin
      chk("l_vld",   32'(l_vld),   32'd1);
      chk("l_n",     32'(l_n),     32'(ls[4*b +: 3]));
      chk("l_cnt",   32'(l_cnt),   32'(b));
      chk("l_last",  32'(l_last),  32'(b == int'(v.nb) - 1));
      chk("l_empty", 32'(l_empty), 32'(v.empty));
      chk("m_n",     32'(m_n),     32'(ms[4*b +: 3]));
      chk("m_last",  32'(m_last),  32'(b == int'(v.nb) - 1));
      tick();
    end
    chk("l_vld_after", 32'(l_vld), 32'd0);
    chk("m_vld_after", 32'(m_vld), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'hA6, 4'd4, 32'h0000_7521, 32'h0000_1257, 1'b0};
    tbl[1] = '{8'h00, 4'd1, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[2] = '{8'h80, 4'd1, 32'h0000_0007, 32'h0000_0007, 1'b0};
    tbl[3] = '{8'h01, 4'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[4] = '{8'hFF, 4'd8, 32'h7654_3210, 32'h0123_4567, 1'b0};
    tbl[5] = '{8'h18, 4'd2, 32'h0000_0043, 32'h0000_0034, 1'b0};
    tbl[6] = '{8'h55, 4'd4, 32'h0000_6420, 32'h0000_0246, 1'b0};

    rst = 1'b1; in_vld = 1'b0; in_x = 8'h00; out_rdy = 1'b1;
    tick(); tick();
    chk("rst_vld",   32'(l_vld),    32'd0);
    chk("rst_n",     32'(l_n),      32'd0);
    chk("rst_cnt",   32'(l_cnt),    32'd0);
    chk("rst_last",  32'(l_last),   32'd0);
    chk("rst_empty", 32'(l_empty),  32'd0);
    chk("rst_rdy",   32'(l_in_rdy), 32'd1);
    rst = 1'b0;
    tick();
    chk("idle_rdy", 32'(l_in_rdy), 32'd1);

    for (int i = 0; i < 7; i++) send(tbl[i]);

    // Back-to-back: 81 then 02 with in_vld held high.
    in_vld = 1'b1; in_x = 8'h81;
    tick();
    in_x = 8'h02;
    chk("b2b_n0",   32'(l_n),      32'd0);
    chk("b2b_rdy0", 32'(l_in_rdy), 32'd0);
    chk("b2b_m_n0", 32'(m_n),      32'd7);
    tick();
    chk("b2b_n1",    32'(l_n),      32'd7);
    chk("b2b_last1", 32'(l_last),   32'd1);
    chk("b2b_rdy1",  32'(l_in_rdy), 32'd1);
    chk("b2b_m_n1",  32'(m_n),      32'd0);
    tick();
    in_vld = 1'b0;
    chk("b2b_vld2",  32'(l_vld),   32'd1);
    chk("b2b_n2",    32'(l_n),     32'd1);
    chk("b2b_cnt2",  32'(l_cnt),   32'd0);
    chk("b2b_last2", 32'(l_last),  32'd1);
    chk("b2b_m_n2",  32'(m_n),     32'd1);
    tick();
    chk("b2b_idle", 32'(l_vld), 32'd0);

    // Backpressure on 0F after beat 0; a competing vector must be ignored.
    in_vld = 1'b1; in_x = 8'h0F;
    tick();
    in_x = 8'hF0; out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_n",   32'(l_n),      32'd0);
      chk("bp_hold_vld", 32'(l_vld),    32'd1);
      chk("bp_hold_rdy", 32'(l_in_rdy), 32'd0);
      chk("bp_hold_cnt", 32'(l_cnt),    32'd0);
    end
    out_rdy = 1'b1; in_vld = 1'b0;
    for (int b = 1; b < 4; b++) begin
      tick();
      chk("bp_n",   32'(l_n),    32'(b));
      chk("bp_cnt", 32'(l_cnt),  32'(b));
      chk("bp_last", 32'(l_last), 32'(b == 3));
    end
    tick();
    chk("bp_idle", 32'(l_vld), 32'd0);

    // Reset during beat 1 of FF aborts the vector.
    in_vld = 1'b1; in_x = 8'hFF;
    tick();
    in_vld = 1'b0;
    tick();
    chk("rst_mid_n1", 32'(l_n), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_vld", 32'(l_vld),    32'd0);
    chk("rst_mid_rdy", 32'(l_in_rdy), 32'd1);
    tick();
    rst = 1'b0;
    chk("rst_mid_still", 32'(l_vld), 32'd0);
    send('{8'h10, 4'd1, 32'h0000_0004, 32'h0000_0004, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
